// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline-control signals between the hazard sequencer and the datapath.
// The slave side (sequencer) samples hazard/branch/memory inputs and drives stall/flush controls.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs_i;
    logic [4:0]       id_rt_i;
    logic             id_uses_rt_i;
    logic             ex_load_i;
    logic [4:0]       ex_rt_i;
    logic             branch_taken_i;
    // Memory handshake: dmem_req_i marks an access issued by MEM; the access is
    // complete in the cycle dmem_ack_i is high. Req and ack together complete at once.
    logic             dmem_req_i;
    logic             dmem_ack_i;
    logic             pc_write_o;
    logic             if_id_stall_o;
    logic             if_id_flush_o;
    logic             id_ex_stall_o;
    logic             id_ex_flush_o;
    logic             ex_mem_stall_o;
    logic             mem_wb_flush_o;
    logic             busy_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, ex_load_i, ex_rt_i,
               branch_taken_i, dmem_req_i, dmem_ack_i,
        output pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
               id_ex_flush_o, ex_mem_stall_o, mem_wb_flush_o, busy_o,
               err_o, stall_cnt_o
    );

    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, ex_load_i, ex_rt_i,
               branch_taken_i, dmem_req_i, dmem_ack_i,
        input  pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
               id_ex_flush_o, ex_mem_stall_o, mem_wb_flush_o, busy_o,
               err_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use bubbles, branch flush,
// full freeze during outstanding data-memory accesses, stall counter and timeout flag.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    pipe_hazard_ctrl_if.slave     bus
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic hz, mw, enter_wait;
    logic pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic ex_mem_stall, mem_wb_flush;

    assign hz = bus.ex_load_i && (bus.ex_rt_i != 5'd0) &&
                ((bus.ex_rt_i == bus.id_rs_i) ||
                 (bus.id_uses_rt_i && (bus.ex_rt_i == bus.id_rt_i)));
    assign enter_wait = (state_q == RUN) && bus.dmem_req_i && !bus.dmem_ack_i;
    assign mw = (state_q == MEM_WAIT) || enter_wait;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // New requests while waiting are ignored: EX_MEM is frozen and still holds them.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (enter_wait)     state_d = MEM_WAIT;
            MEM_WAIT: if (bus.dmem_ack_i) state_d = RUN;
            default:                      state_d = RUN;
        endcase
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        if (!rst_i) begin
            pc_write = 1'b0;
        end else if (mw) begin
            pc_write     = 1'b0;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (hz) begin
            // The branch is left to re-resolve once the bubble has passed.
            pc_write    = 1'b0;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end else if (bus.branch_taken_i) begin
            if_id_flush = 1'b1;
        end
    end

    always_comb begin
        tmo_d = tmo_q;
        err_d = err_q;
        cnt_d = cnt_q;
        if (enter_wait) begin
            tmo_d = '0;
        end else if (state_q == MEM_WAIT) begin
            if (tmo_q != TW'(MEM_TIMEOUT)) tmo_d = tmo_q + TW'(1);
            if (tmo_d == TW'(MEM_TIMEOUT)) err_d = 1'b1;
        end
        if (!pc_write && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.pc_write_o     = pc_write;
    assign bus.if_id_stall_o  = if_id_stall;
    assign bus.if_id_flush_o  = if_id_flush;
    assign bus.id_ex_stall_o  = id_ex_stall;
    assign bus.id_ex_flush_o  = id_ex_flush;
    assign bus.ex_mem_stall_o = ex_mem_stall;
    assign bus.mem_wb_flush_o = mem_wb_flush;
    assign bus.busy_o         = (state_q == MEM_WAIT);
    assign bus.err_o          = err_q;
    assign bus.stall_cnt_o    = cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: single-cycle vector table plus
// memory-wait, timeout, saturation and mid-wait reset sequences.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W       = 3;
    localparam int MEM_TIMEOUT = 4;

    // Control outputs packed as {pc_write, if_id_stall, if_id_flush, id_ex_stall,
    // id_ex_flush, ex_mem_stall, mem_wb_flush}.
    localparam logic [6:0] O_RUN   = 7'b1000000;
    localparam logic [6:0] O_HZ    = 7'b0100100;
    localparam logic [6:0] O_BR    = 7'b1010000;
    localparam logic [6:0] O_FRZ   = 7'b0101011;
    localparam logic [6:0] O_RESET = 7'b0000000;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rt;
        logic       ld;
        logic [4:0] ert;
        logic       br;
        logic       req;
        logic       ack;
        logic [6:0] exp_o;
    } vec_t;

    logic clk_i;
    logic rst_i;
    int   n_checks;
    int   n_errors;
    int   exp_cnt;
    vec_t vecs[10];

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] outv();
        return {bus.pc_write_o, bus.if_id_stall_o, bus.if_id_flush_o, bus.id_ex_stall_o,
                bus.id_ex_flush_o, bus.ex_mem_stall_o, bus.mem_wb_flush_o};
    endfunction

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                          input logic ld, input logic [4:0] ert, input logic br,
                          input logic req, input logic ack);
        bus.id_rs_i        = rs;
        bus.id_rt_i        = rt;
        bus.id_uses_rt_i   = use_rt;
        bus.ex_load_i      = ld;
        bus.ex_rt_i        = ert;
        bus.branch_taken_i = br;
        bus.dmem_req_i     = req;
        bus.dmem_ack_i     = ack;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b0;
        #3;
        rst_i = 1'b1;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_i    = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);

        vecs[0] = '{"idle",          0, 0, 0, 0, 0, 0, 0, 0, O_RUN};
        vecs[1] = '{"loaduse_rs",    5, 0, 0, 1, 5, 0, 0, 0, O_HZ};
        vecs[2] = '{"load_r0",       0, 0, 1, 1, 0, 0, 0, 0, O_RUN};
        vecs[3] = '{"rt_unused",     3, 5, 0, 1, 5, 0, 0, 0, O_RUN};
        vecs[4] = '{"loaduse_rt",    3, 5, 1, 1, 5, 0, 0, 0, O_HZ};
        vecs[5] = '{"branch",        0, 0, 0, 0, 0, 1, 0, 0, O_BR};
        vecs[6] = '{"branch_hz",     7, 0, 0, 1, 7, 1, 0, 0, O_HZ};
        vecs[7] = '{"req_ack_same",  0, 0, 0, 0, 0, 0, 1, 1, O_RUN};
        vecs[8] = '{"req_ack_hz",    9, 0, 0, 1, 9, 0, 1, 1, O_HZ};
        vecs[9] = '{"no_load_match", 4, 0, 0, 0, 4, 0, 0, 0, O_RUN};

        // Reset state
        #3;
        chk("reset_outs",  32'(outv()), 32'(O_RESET));
        chk("reset_busy",  32'(bus.busy_o), 32'd0);
        chk("reset_err",   32'(bus.err_o), 32'd0);
        chk("reset_cnt",   32'(bus.stall_cnt_o), 32'd0);
        tick();

        // Single-cycle vectors
        do_reset();
        exp_cnt = 0;
        foreach (vecs[i]) begin
            set_in(vecs[i].rs, vecs[i].rt, vecs[i].use_rt, vecs[i].ld, vecs[i].ert,
                   vecs[i].br, vecs[i].req, vecs[i].ack);
            #3;
            chk({"outs_", vecs[i].name}, 32'(outv()), 32'(vecs[i].exp_o));
            chk({"busy_", vecs[i].name}, 32'(bus.busy_o), 32'd0);
            if (vecs[i].exp_o[6] == 1'b0 && exp_cnt < 7) exp_cnt++;
            tick();
            chk({"cnt_", vecs[i].name}, 32'(bus.stall_cnt_o), 32'(exp_cnt));
        end

        // Memory wait: request cycle + 3 wait cycles, ack in the last one
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        #3;
        chk("mw_req_outs", 32'(outv()), 32'(O_FRZ));
        chk("mw_req_busy", 32'(bus.busy_o), 32'd0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        #3;
        chk("mw_w1_outs", 32'(outv()), 32'(O_FRZ));
        chk("mw_w1_busy", 32'(bus.busy_o), 32'd1);
        tick();
        set_in(6, 0, 0, 1, 6, 1, 0, 0);
        #3;
        chk("mw_w2_outs", 32'(outv()), 32'(O_FRZ));
        chk("mw_w2_busy", 32'(bus.busy_o), 32'd1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        #3;
        chk("mw_ack_outs", 32'(outv()), 32'(O_FRZ));
        chk("mw_ack_busy", 32'(bus.busy_o), 32'd1);
        chk("mw_ack_cnt",  32'(bus.stall_cnt_o), 32'd3);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("mw_done_outs", 32'(outv()), 32'(O_RUN));
        chk("mw_done_busy", 32'(bus.busy_o), 32'd0);
        chk("mw_done_cnt",  32'(bus.stall_cnt_o), 32'd4);
        chk("mw_done_err",  32'(bus.err_o), 32'd0);
        tick();

        // Timeout: never ack, err rises after MEM_TIMEOUT wait cycles
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= MEM_TIMEOUT; i++) begin
            #3;
            chk($sformatf("to_pre_err_%0d", i), 32'(bus.err_o), 32'd0);
            chk($sformatf("to_busy_%0d", i), 32'(bus.busy_o), 32'd1);
            tick();
        end
        chk("to_err_set", 32'(bus.err_o), 32'd1);
        tick();
        tick();
        chk("to_err_hold", 32'(bus.err_o), 32'd1);
        chk("to_busy_hold", 32'(bus.busy_o), 32'd1);
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        #3;
        chk("to_ack_outs", 32'(outv()), 32'(O_FRZ));
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("to_after_busy", 32'(bus.busy_o), 32'd0);
        chk("to_after_err",  32'(bus.err_o), 32'd1);
        chk("to_after_outs", 32'(outv()), 32'(O_RUN));
        chk("to_after_cnt",  32'(bus.stall_cnt_o), 32'd7);
        tick();

        // Saturation: hold a load-use hazard for 10 cycles
        do_reset();
        set_in(5, 0, 0, 1, 5, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            #3;
            chk($sformatf("sat_outs_%0d", i), 32'(outv()), 32'(O_HZ));
            tick();
            chk($sformatf("sat_cnt_%0d", i), 32'(bus.stall_cnt_o), (i + 1 < 7) ? 32'(i + 1) : 32'd7);
        end

        // Asynchronous reset in the middle of a long wait
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("rst_pre_err",  32'(bus.err_o), 32'd1);
        chk("rst_pre_busy", 32'(bus.busy_o), 32'd1);
        #1;
        rst_i = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_mid_err",  32'(bus.err_o), 32'd0);
        chk("rst_mid_cnt",  32'(bus.stall_cnt_o), 32'd0);
        chk("rst_mid_outs", 32'(outv()), 32'(O_RESET));
        #1;
        rst_i = 1'b1;
        tick();
        chk("rst_post_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_post_outs", 32'(outv()), 32'(O_RUN));
        chk("rst_post_cnt",  32'(bus.stall_cnt_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
